// File: rtl/clk_div_mon_pkg.sv
// Shared types and helpers for the divided-clock monitor: FSM state encoding
// and the half-period tolerance comparison.
package clk_div_mon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ACQUIRE,
    LOCKED,
    FAULT
  } state_t;

  // Checks exp_half - tol <= half <= exp_half + tol. The lower bound is moved
  // to the left side so that no subtraction is needed, and the sums carry one
  // extra bit so they cannot overflow.
  function automatic logic in_tol(input logic [31:0] half,
                                  input logic [31:0] exp_half,
                                  input logic [31:0] tol);
    logic [32:0] half_plus_tol;
    logic [32:0] exp_plus_tol;
    half_plus_tol = {1'b0, half} + {1'b0, tol};
    exp_plus_tol  = {1'b0, exp_half} + {1'b0, tol};
    return (half_plus_tol >= {1'b0, exp_half}) && ({1'b0, half} <= exp_plus_tol);
  endfunction

endpackage

// File: rtl/clk_div_mon_sync.sv
// Brings the asynchronous divided clock into the clk domain through two flops,
// then compares against one history flop to produce rise/fall strobes.
module clk_div_mon_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic div_in,
  output logic rise,
  output logic fall,
  output logic level
);

  logic sync1;
  logic sync2;
  logic hist;

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // chain samples its pre-edge input; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= div_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // A glitch that never reaches sync2 is lost; one that does yields exactly
  // one rise/fall pair, never a double edge in the same direction.
  assign rise  = sync2 & ~hist;
  assign fall  = ~sync2 & hist;
  assign level = sync2;

endmodule

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: edge detection, half-period measurement, lock/fault FSM.
// Optional statistics counters are compiled in with CLK_DIV_MON_STATS_EN.
module clk_div_monitor
  import clk_div_mon_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int EXP_HALF = 4,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_in,
  input  logic             enable,
  input  logic             err_clr,
  output logic             edge_rise,
  output logic             edge_fall,
  output logic [CNT_W-1:0] half_period,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout,
`ifdef CLK_DIV_MON_STATS_EN
  output logic [15:0]      edge_count,
  output logic [7:0]       fault_count,
`endif
  output logic             err
);

  localparam int               GOOD_W  = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [GOOD_W-1:0] good;
  logic [GOOD_W-1:0] good_nxt;
  logic              err_nxt;

  logic sync_rise;
  logic sync_fall;
  logic sync_level;
  logic det_en;
  logic det_rise;
  logic det_fall;
  logic det_edge;
  logic measure;
  logic tol_ok;
  logic fault_ev;

  clk_div_mon_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_in (div_in),
    .rise   (sync_rise),
    .fall   (sync_fall),
    .level  (sync_level)
  );

  // Edges are only acted on while the monitor is running.
  assign det_en   = enable && (state != IDLE);
  assign det_rise = det_en && sync_rise && sync_level;
  assign det_fall = det_en && sync_fall && !sync_level;
  assign det_edge = det_rise || det_fall;
  assign measure  = det_edge && (state == ACQUIRE || state == LOCKED || state == FAULT);
  assign cnt_inc  = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;

  // The FSM acts on the registered measurement and timeout one cycle later.
  assign tol_ok   = in_tol(32'(half_period), 32'(EXP_HALF), 32'(TOL));
  assign fault_ev = (meas_valid && !tol_ok) || timeout;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    err_nxt   = err;
    if (!enable) begin
      state_nxt = IDLE;
      good_nxt  = '0;
    end else begin
      case (state)
        IDLE:    state_nxt = START;
        START:   if (det_edge) state_nxt = ACQUIRE;
        ACQUIRE: begin
          if (meas_valid && tol_ok) begin
            good_nxt = good + 1'b1;
            if (good_nxt == GOOD_W'(LOCK_CNT)) state_nxt = LOCKED;
          end else if (fault_ev) begin
            good_nxt = '0;
          end
        end
        LOCKED: begin
          if (fault_ev) begin
            state_nxt = FAULT;
            err_nxt   = 1'b1;
          end
        end
        FAULT: begin
          // A fresh fault outranks a simultaneous clear request.
          if (fault_ev) begin
            err_nxt = 1'b1;
          end else if (err_clr) begin
            state_nxt = START;
            err_nxt   = 1'b0;
            good_nxt  = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      good        <= '0;
      err         <= 1'b0;
      locked      <= 1'b0;
      cnt         <= '0;
      edge_rise   <= 1'b0;
      edge_fall   <= 1'b0;
      meas_valid  <= 1'b0;
      half_period <= '0;
      timeout     <= 1'b0;
    end else begin
      state      <= state_nxt;
      good       <= good_nxt;
      err        <= err_nxt;
      locked     <= (state_nxt == LOCKED);
      edge_rise  <= det_rise;
      edge_fall  <= det_fall;
      meas_valid <= measure;
      if (measure) half_period <= cnt_inc;
      // Saturation keeps cnt away from TO_LAST, so one edgeless gap times out once.
      timeout <= det_en && !det_edge && (cnt == TO_LAST);
      if (!det_en || det_edge) cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
  end

`ifdef CLK_DIV_MON_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_count  <= '0;
      fault_count <= '0;
    end else begin
      if (det_rise && edge_count != 16'hFFFF) edge_count <= edge_count + 1'b1;
      if (state != FAULT && state_nxt == FAULT && fault_count != 8'hFF)
        fault_count <= fault_count + 1'b1;
    end
  end
`endif

endmodule
